// File: rtl/fir_pkg.sv
// Shared types for the fir datapath and its output stage.
// Sample/tap typedefs plus the saturating drop-counter helper.
package fir_pkg;
    localparam int SAMPLE_W = 16;
    typedef logic [SAMPLE_W-1:0] sample_t;

    localparam int NUM_TAPS = 10;
    typedef sample_t [NUM_TAPS-1:0] taps_t;

    localparam int DROP_W = 8;
    typedef logic [DROP_W-1:0] drop_cnt_t;

    function automatic drop_cnt_t sat_inc(input drop_cnt_t v);
        return (v == '1) ? v : v + drop_cnt_t'(1);
    endfunction
endpackage

// File: rtl/sample_fifo.sv
// Generic register FIFO with combinational head read and cleared storage.
// Latency: write visible at rdata one clock after push into an empty FIFO.
// Backpressure: push while full is ignored unless a pop happens the same cycle.
module sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == LW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop frees the slot the simultaneous push lands in, so full+pop still accepts.
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];
    assign level   = count;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/fir_decim_out.sv
// Decimates the fir output stream by DECIM and buffers kept samples for a valid/ready consumer.
// Latency: kept sample shows on out_data/out_valid one clock after its input edge (empty FIFO).
// Backpressure: kept samples arriving while full with no pop are dropped and counted (ovf, drop_cnt).
module fir_decim_out
    import fir_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W,
    parameter int DECIM = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         y,
    input  logic                     y_valid,
    input  logic                     clear_ovf,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    output logic [DROP_W-1:0]        drop_cnt
);
    localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [PH_W-1:0] phase;
    logic            keep_vld;
    logic            pop_vld;
    logic            drop_vld;
    logic            fifo_full;
    logic            fifo_empty;

    assign keep_vld  = y_valid & (phase == '0);
    assign out_valid = ~fifo_empty;
    assign pop_vld   = out_valid & out_ready;
    assign drop_vld  = keep_vld & fifo_full & ~pop_vld;

    always_ff @(posedge clock) begin
        if (reset) begin
            phase <= '0;
        end else if (y_valid) begin
            phase <= (phase == PH_W'(DECIM - 1)) ? '0 : phase + PH_W'(1);
        end
    end

    // A drop in the same cycle as clear_ovf restarts the count at one.
    always_ff @(posedge clock) begin
        if (reset) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else if (drop_vld) begin
            ovf      <= 1'b1;
            drop_cnt <= clear_ovf ? drop_cnt_t'(1) : sat_inc(drop_cnt);
        end else if (clear_ovf) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end
    end

    sample_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (keep_vld),
        .pop   (pop_vld),
        .wdata (y),
        .rdata (out_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (level)
    );
endmodule

// File: doc/fir_decim_out.md
Name: fir_decim_out

Overview:
- Output stage directly downstream of fir: consumes the filtered 16-bit stream y, one sample per clock when valid.
- Keeps every DECIM-th sample and buffers kept samples in a small FIFO.
- Presents buffered samples on a valid/ready interface to the next consumer (DMA / DAC framer).
- Reports drops caused by downstream backpressure through a sticky overflow flag and a drop counter.

Parameters:
- WIDTH, 16, sample width (matches fir y).
- DECIM, 4, decimation ratio, legal range 1..16.
- DEPTH, 4, FIFO entries, power of two, range 2..16.

Ports:
- clock  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- y  in  WIDTH  filtered sample from fir.
- y_valid  in  1  y is a new sample this cycle.
- clear_ovf  in  1  clears ovf and drop_cnt.
- out_data  out  WIDTH  FIFO head sample.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts out_data this cycle.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- ovf  out  1  sticky: at least one kept sample was dropped.
- drop_cnt  out  8  dropped-sample count, saturates at 255.

Behaviour:
- Reset: synchronous, active-high, with the clock and reset polarity/synchronicity fixed as above. The cycle after reset is sampled high, all outputs are 0: out_data=0, out_valid=0, level=0, ovf=0, drop_cnt=0. The phase counter and FIFO pointers are cleared. Storage entries are cleared so out_data never shows X.
- Reset mid-operation: all buffered samples are discarded; no pop is reported that cycle.
- Phase counter: range 0..DECIM-1. Advances only on y_valid and wraps DECIM-1 -> 0.
- Sample selection: a sample is "kept" when y_valid=1 and phase==0. The first valid sample after reset is always kept. DECIM=1 keeps every valid sample.
- Push: a kept sample is written on the same posedge.
- Latency: a kept sample at edge N appears at out_data/out_valid after edge N (one clock) when the FIFO was empty.
- Pop: occurs when out_valid & out_ready. The head advances on that edge.
- out_data: combinational read of the head register. It holds its value while out_valid & !out_ready.
- Full + kept sample, no pop: the sample is dropped and the FIFO contents are unchanged. ovf is set to 1 and drop_cnt increments, saturating at 255.
- Full + kept sample + pop in the same cycle: push is accepted, no drop, level unchanged.
- Empty + kept sample + out_ready: no same-cycle bypass. The sample is stored, and level becomes 1.
- level update: +1 on push only, -1 on pop only, unchanged on both or neither.
- clear_ovf: next cycle ovf=0 and drop_cnt=0. If a drop occurs in the same cycle, the drop wins: ovf=1, drop_cnt=1.
- Width rules: no arithmetic on sample data; samples pass bit-exact. Pointers wrap modulo DEPTH.

Decomposition:
- Package fir_pkg holds:
  - SAMPLE_W = 16, with typedef sample_t = logic [SAMPLE_W-1:0].
  - NUM_TAPS = 10, with typedef taps_t as an array of sample_t.
  - fir and fir_decim_out both import the package.
- Sub-module sample_fifo (parameters WIDTH, DEPTH):
  - Inputs push, pop, wdata; outputs rdata, empty, full, level.
  - Implements the push-when-full-with-pop rule.
- fir_decim_out contains only the phase counter, keep logic and drop/ovf bookkeeping around sample_fifo.

Test Plan:
- Basic decimation: DECIM=4, out_ready=1, y_valid=1 with y=0,1,2,...,15 -> out_data sequence 0,4,8,12. Each appears one cycle after input, ovf=0.
- Gapped input: DECIM=4, y_valid high only on odd cycles carrying 100,101,...,107 -> kept samples are 100 and 104.
- Backpressure overflow: DECIM=1, DEPTH=4, out_ready=0, 6 valid samples 10..15 -> level=4, FIFO holds 10..13, ovf=1, drop_cnt=2. Then out_ready=1 drains 10,11,12,13.
- Full with simultaneous pop: FIFO full (10..13), out_ready=1, new kept sample 14 -> level stays 4, no drop, next heads are 11,12,13,14.
- Clear vs drop race: ovf=1, drop_cnt=5, clear_ovf=1 in the same cycle as a drop -> ovf=1, drop_cnt=1. A clear with no drop -> 0, 0.
- Mid-stream reset: level=3, reset asserted for 1 cycle -> out_valid=0, level=0, drop_cnt=0. The next valid sample 77 is kept regardless of the prior phase and appears one cycle later.
